// File: rtl/pwrseq_rail_seq_pkg.sv
// Shared state encodings, parameter defaults and index helpers for the rail sequencer.
package pwrseq_rail_seq_pkg;

    localparam int STATE_W = 3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PUP     = 3'd1;
    localparam logic [2:0] ST_STEADY  = 3'd2;
    localparam logic [2:0] ST_PDN     = 3'd3;
    localparam logic [2:0] ST_RETRY   = 3'd4;
    localparam logic [2:0] ST_LOCKOUT = 3'd5;

    localparam int DEF_NUM_RAILS       = 5;
    localparam int DEF_WDT_NBITS       = 10;
    localparam int DEF_PUP_TIMEOUT_VAL = 112;
    localparam int DEF_PDN_DELAY_VAL   = 2;
    localparam int DEF_MAX_RETRY       = 2;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [3:0] lowest_set(input logic [15:0] vec);
        lowest_set = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) lowest_set = 4'(i);
        end
    endfunction

    // Index of the highest set bit; 0 when the vector is empty.
    function automatic logic [3:0] highest_set(input logic [15:0] vec);
        highest_set = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (vec[i]) highest_set = 4'(i);
        end
    endfunction

endpackage

// File: rtl/pwrseq_wdt.sv
// Tick-based watchdog: counts seq_tick, saturates at all-ones, flags when the
// count reaches the selected limit on a tick.
module pwrseq_wdt #(
    parameter int WDT_NBITS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 tick,
    input  logic [WDT_NBITS-1:0] limit,
    output logic                 hit
);

    logic [WDT_NBITS-1:0] cnt_q;
    logic [WDT_NBITS-1:0] cnt_d;
    logic [WDT_NBITS-1:0] cnt_inc;

    // NOTE: every combinational output gets a default first, so no path holds a stale value (no latch).
    always_comb begin
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        hit     = tick && (cnt_inc == limit);
        cnt_d   = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_inc;
        end
    end

    // NOTE: non-blocking assignments make every flop update from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwrseq_rail_seq.sv
// Power rail sequencer: enables rails in order, watches pgood, powers down in
// reverse order, retries after faults and locks out after too many.
module pwrseq_rail_seq
    import pwrseq_rail_seq_pkg::*;
#(
    parameter int NUM_RAILS       = DEF_NUM_RAILS,
    parameter int WDT_NBITS       = DEF_WDT_NBITS,
    parameter int PUP_TIMEOUT_VAL = DEF_PUP_TIMEOUT_VAL,
    parameter int PDN_DELAY_VAL   = DEF_PDN_DELAY_VAL,
    parameter int MAX_RETRY       = DEF_MAX_RETRY
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 seq_tick,
    input  logic                 pwr_on_req,
    input  logic                 pwr_off_req,
    input  logic                 fault_clear,
    input  logic [NUM_RAILS-1:0] rail_pgood,
    output logic [NUM_RAILS-1:0] rail_en,
    output logic                 pwrok,
    output logic [STATE_W-1:0]   seq_state,
    output logic [NUM_RAILS-1:0] fault_rail,
    output logic [1:0]           retry_cnt,
    output logic                 lockout
);

    localparam int                   IDX_W       = $clog2(NUM_RAILS);
    localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(NUM_RAILS - 1);
    localparam logic [WDT_NBITS-1:0] PUP_LIMIT   = WDT_NBITS'(PUP_TIMEOUT_VAL);
    localparam logic [WDT_NBITS-1:0] PDN_LIMIT   = WDT_NBITS'(PDN_DELAY_VAL);
    localparam logic [1:0]           RETRY_LIMIT = 2'(MAX_RETRY);

    logic [STATE_W-1:0]   state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_RAILS-1:0] rail_en_q, rail_en_d;
    logic                 pwrok_q, pwrok_d;
    logic [NUM_RAILS-1:0] fault_rail_q, fault_rail_d;
    logic [1:0]           retry_cnt_q, retry_cnt_d;
    logic                 lockout_q, lockout_d;

    logic                 wdt_clr;
    logic                 wdt_hit;
    logic [WDT_NBITS-1:0] wdt_limit;
    logic [NUM_RAILS-1:0] below_idx;
    logic [NUM_RAILS-1:0] drop_vec;
    logic                 fault_now;
    logic [3:0]           fault_idx;
    logic                 enter_pdn;

    // One timer serves the per-rail power-up timeout and every delay period.
    assign wdt_limit = (state_q == ST_PUP) ? PUP_LIMIT : PDN_LIMIT;

    pwrseq_wdt #(
        .WDT_NBITS(WDT_NBITS)
    ) u_wdt (
        .clk  (clk),
        .reset(reset),
        .clr  (wdt_clr),
        .tick (seq_tick),
        .limit(wdt_limit),
        .hit  (wdt_hit)
    );

    // Fault detection: a pgood drop on an already-good rail beats the timeout.
    always_comb begin
        below_idx = '0;
        for (int i = 0; i < NUM_RAILS; i++) begin
            below_idx[i] = (i < int'(idx_q));
        end
        case (state_q)
            ST_PUP:    drop_vec = below_idx & rail_en_q & ~rail_pgood;
            ST_STEADY: drop_vec = ~rail_pgood;
            default:   drop_vec = '0;
        endcase
        fault_now = 1'b0;
        fault_idx = 4'd0;
        if (drop_vec != '0) begin
            fault_now = 1'b1;
            fault_idx = lowest_set(16'(drop_vec));
        end else if ((state_q == ST_PUP) && wdt_hit) begin
            fault_now = 1'b1;
            fault_idx = 4'(idx_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rail_en_d    = rail_en_q;
        fault_rail_d = fault_rail_q;
        retry_cnt_d  = retry_cnt_q;
        wdt_clr      = 1'b0;
        enter_pdn    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                wdt_clr = 1'b1;
                if (pwr_on_req && !pwr_off_req) begin
                    state_d      = ST_PUP;
                    idx_d        = '0;
                    rail_en_d[0] = 1'b1;
                end
            end
            ST_PUP: begin
                if (fault_now || pwr_off_req) begin
                    enter_pdn = 1'b1;
                end else if (rail_pgood[idx_q]) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_STEADY;
                    end else begin
                        idx_d                     = idx_q + 1'b1;
                        rail_en_d[idx_q + 1'b1]   = 1'b1;
                        wdt_clr                   = 1'b1;
                    end
                end
            end
            ST_STEADY: begin
                wdt_clr = 1'b1;
                if (fault_now || pwr_off_req) enter_pdn = 1'b1;
            end
            ST_PDN: begin
                if (wdt_hit) begin
                    wdt_clr = 1'b1;
                    if (rail_en_q != '0) begin
                        rail_en_d[idx_q] = 1'b0;
                        idx_d            = idx_q - 1'b1;
                    end else begin
                        idx_d = '0;
                        if (fault_rail_q == '0) begin
                            state_d     = ST_IDLE;
                            retry_cnt_d = '0;
                        end else if (retry_cnt_q < RETRY_LIMIT) begin
                            state_d     = ST_RETRY;
                            retry_cnt_d = retry_cnt_q + 1'b1;
                        end else begin
                            state_d = ST_LOCKOUT;
                        end
                    end
                end
            end
            ST_RETRY: begin
                if (pwr_off_req) begin
                    state_d = ST_IDLE;
                    wdt_clr = 1'b1;
                end else if (wdt_hit) begin
                    state_d      = ST_PUP;
                    idx_d        = '0;
                    rail_en_d[0] = 1'b1;
                    fault_rail_d = '0;
                    wdt_clr      = 1'b1;
                end
            end
            ST_LOCKOUT: begin
                wdt_clr   = 1'b1;
                rail_en_d = '0;
                if (fault_clear) begin
                    state_d      = ST_IDLE;
                    fault_rail_d = '0;
                    retry_cnt_d  = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                idx_d     = '0;
                rail_en_d = '0;
            end
        endcase

        // Power-down always starts from the highest rail currently enabled.
        if (enter_pdn) begin
            state_d = ST_PDN;
            wdt_clr = 1'b1;
            idx_d   = IDX_W'(highest_set(16'(rail_en_q)));
            if (fault_now && (fault_rail_q == '0)) begin
                fault_rail_d = NUM_RAILS'(1) << fault_idx;
            end
        end

        pwrok_d   = (state_d == ST_STEADY);
        lockout_d = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            rail_en_q    <= '0;
            pwrok_q      <= 1'b0;
            fault_rail_q <= '0;
            retry_cnt_q  <= '0;
            lockout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rail_en_q    <= rail_en_d;
            pwrok_q      <= pwrok_d;
            fault_rail_q <= fault_rail_d;
            retry_cnt_q  <= retry_cnt_d;
            lockout_q    <= lockout_d;
        end
    end

    assign rail_en    = rail_en_q;
    assign pwrok      = pwrok_q;
    assign seq_state  = state_q;
    assign fault_rail = fault_rail_q;
    assign retry_cnt  = retry_cnt_q;
    assign lockout    = lockout_q;

endmodule
